instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the instruction decoder: accepts instruction fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Writes the packed words sequentially into instruction ROM/RAM through a single write port.
- Serves as the program loader for the single-cycle processor.
- Bit layout matches the decoder field map exactly.

Parameters:
- AW, 8, instruction-memory address width.
- DEPTH, 256, maximum words per load session; must satisfy 1 <= DEPTH <= 2^AW.
- BASE_ADDR, 0, first write address of each session.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  pulse; begins a load session
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_type  input  2  00=R, 01=I, 10=J, 11=illegal
- in_opcode  input  6  opcode
- in_rd  input  5  R-type rd
- in_rs  input  5  R-type rs
- in_rt  input  5  R-type rt
- in_shamt  input  5  R-type shamt
- in_imm  input  16  I-type constant/adr
- in_addr  input  16  J-type address
- in_last  input  1  bundle is the final instruction of the session
- mem_we  output  1  instruction-memory write strobe
- mem_addr  output  AW  write address
- mem_wdata  output  32  packed instruction word
- busy  output  1  session in progress (LOAD or WRITE)
- done  output  1  session complete
- err  output  1  sticky; illegal bundle seen this session
- count  output  AW+1  words written this session

Behaviour:
- Packing, bit 31 = 0 unless the optional feature below is compiled in:
  - R: [5:0]=opcode, [10:6]=rd, [15:11]=rs, [20:16]=rt, [25:21]=shamt, [31:26]=0.
  - I: [5:0]=opcode, [9:6]=0, [25:10]=imm, [31:26]=0.
  - J: [5:0]=opcode, [21:6]=addr, [31:22]=0.
- Packing is combinational from the inputs; the result is registered into mem_wdata on the accepting edge.
- Reset: state=IDLE. in_ready, mem_we, busy, done, err = 0; mem_addr=BASE_ADDR; mem_wdata=0; count=0.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1: mem_addr<=BASE_ADDR, count<=0, err<=0, go to LOAD.
- LOAD:
  - in_ready=1, busy=1.
  - Accept when in_valid && in_ready.
  - Legal type: latch packed word and in_last, go to WRITE.
  - in_type=11: no write; err<=1; stay in LOAD. in_last on an illegal bundle still ends the session: go to DONE.
- WRITE:
  - mem_we=1 for exactly one cycle with current mem_addr/mem_wdata; in_ready=0.
  - Next edge: mem_addr<=mem_addr+1 (wraps modulo 2^AW), count<=count+1.
  - If latched last=1 or count+1==DEPTH, go to DONE; else go to LOAD.
- Throughput: one instruction per 2 cycles. Latency: accept edge -> mem_we high the following cycle.
- DONE:
  - done=1, busy=0, in_ready=0; count and err held.
  - start=1: begin a new session exactly as from IDLE.
- start asserted in LOAD or WRITE is ignored.
- in_valid held with in_ready=0 is never accepted; bundle contents are don't-care while in_valid=0.
- rst in any state, including the WRITE cycle, returns to reset values on that edge; no partial write follows.
- mem_we is never high outside WRITE.

Optional Feature:
- Macro INSTR_ENC_PARITY_EN.
- Defined: bit 31 of every packed word = XOR of bits [30:0], giving even overall word parity. Bit 31 lies in the decoder's unused field, so decode is unaffected.
- Undefined: bit 31 = 0 always.
- No other behaviour changes.

Test Plan:
- Reset then start, R-type op=7 rd=3 rs=5 rt=9 shamt=2 last=1 -> mem_we one cycle at addr 0, wdata=0x004928C7; then done=1, count=1.
- I-type op=8 imm=0x1234, then J-type op=9 addr=0x00FF last=1 -> writes 0x0048D008 @0 and 0x00003FC9 @1; in_ready low during each WRITE; count=2.
- DEPTH=4, five bundles with last=0 -> exactly 4 writes at addr 0..3; done after the 4th; 5th bundle is not accepted (in_ready=0).
- in_type=11 mid-session -> no mem_we, err=1 stays set until the next start; following legal bundle writes at the next unused address.
- INSTR_ENC_PARITY_EN defined, J-type op=9 addr=0x0001 -> wdata=0x80000049. Undefined -> 0x00000049.
- rst asserted during the WRITE cycle -> mem_we=0 next cycle; state IDLE, count=0, mem_addr=BASE_ADDR; start is required before any further accept.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: program loader that packs R/I/J instruction field bundles
// into 32-bit words and writes them sequentially into instruction memory.
// One bundle is accepted in LOAD. The packed word is then written in the
// following WRITE cycle, so throughput is one word every two cycles.
// Optional build macro INSTR_ENC_PARITY_EN: bit 31 of each word carries even
// parity over bits [30:0]. Without it, bit 31 is always 0.
module instr_encoder #(
   parameter int AW        = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_type,
   input  logic [5:0]    in_opcode,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_shamt,
   input  logic [15:0]   in_imm,
   input  logic [15:0]   in_addr,
   input  logic          in_last,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   count
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [AW-1:0] BASE_C  = AW'(BASE_ADDR);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          last_q, last_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;
   logic [AW:0]   count_inc;
   logic [31:0]   packed_word;

   // Field layout mirrors the decoder; bit 31 sits in the decoder's unused field.
   function automatic logic [31:0] pack_word(
      input logic [1:0]  t,
      input logic [5:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  sh,
      input logic [15:0] imm,
      input logic [15:0] adr
   );
      logic [31:0] w;
      case (t)
         2'b00:   w = {6'd0, sh, rt, rs, rd, op};
         2'b01:   w = {6'd0, imm, 4'd0, op};
         2'b10:   w = {10'd0, adr, op};
         default: w = 32'd0;
      endcase
`ifdef INSTR_ENC_PARITY_EN
      w[31] = ^w[30:0];
`else
      w[31] = 1'b0;
`endif
      return w;
   endfunction

   assign packed_word = pack_word(in_type, in_opcode, in_rd, in_rs, in_rt,
                                  in_shamt, in_imm, in_addr);
   assign count_inc   = count_q + (AW+1)'(1);

   assign in_ready  = (state_q == LOAD);
   assign busy      = (state_q == LOAD) || (state_q == WRITE);
   assign done      = (state_q == DONE);
   assign mem_we    = (state_q == WRITE);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = count_q;
   assign err       = err_q;

   // Next-state logic: session control, bundle acceptance and address/count advance.
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      last_d      = last_q;
      count_d     = count_q;
      err_d       = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mem_addr_d = BASE_C;
               count_d    = '0;
               err_d      = 1'b0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            if (in_valid) begin
               if (in_type == 2'b11) begin
                  // Illegal bundle is dropped but may still close the session.
                  err_d = 1'b1;
                  if (in_last) state_d = DONE;
               end else begin
                  mem_wdata_d = packed_word;
                  last_d      = in_last;
                  state_d     = WRITE;
               end
            end
         end
         WRITE: begin
            mem_addr_d = mem_addr_q + AW'(1);
            count_d    = count_inc;
            if (last_q || (count_inc == DEPTH_C)) state_d = DONE;
            else                                  state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset wins in every state, including WRITE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_addr_q  <= BASE_C;
         mem_wdata_q <= 32'd0;
         last_q      <= 1'b0;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         last_q      <= last_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

endmodule
